add_byte_loader: RTL and testbench

Operand loader and result capture stage wrapped around the N-bit carry-bypass adder core. Assembles A and B from an 8-bit valid/ready byte stream and drives them combinationally into the adder. Waits a programmable settle interval, then registers S/cout/OF and presents them on a valid/ready result port. It is the adder's only upstream source and only downstream consumer.

---
 rtl/add_pkg.sv | 15 +
 rtl/add_byte_loader.sv | 130 +++++++++++++
 tb/tb_add_byte_loader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/add_pkg.sv
// Shared definitions for the adder operand loader and its bench.
package add_pkg;

  localparam int BYTE_W    = 8;
  localparam int N_DEFAULT = 32;
  localparam int NBYTES    = N_DEFAULT / BYTE_W;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    SETTLE = 2'd2,
    OUT    = 2'd3
  } state_t;

endpackage

// File: rtl/add_byte_loader.sv
// Assembles adder operands from a byte stream, waits for the combinational
// adder to settle, then holds the registered result on a valid/ready port.
module add_byte_loader
  import add_pkg::*;
#(
  parameter int N             = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  input  logic         in_cin,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  output logic         add_cin,
  input  logic [N-1:0] add_s,
  input  logic         add_cout,
  input  logic         add_of,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_sum,
  output logic         res_cout,
  output logic         res_of,
  output logic         busy
);

  localparam int NB   = N / BYTE_W;
  localparam int IDXW = $clog2(NB);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NB - 1);
  localparam logic [3:0]      CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            cin_q, cin_d, cout_q, cout_d, of_q, of_d;

  // in_ready is decoded from state alone, so the byte write only needs in_valid.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    of_d    = of_q;
    case (state_q)
      LOAD_A: begin
        if (in_valid) begin
          a_d[int'(idx_q)*BYTE_W +: BYTE_W] = in_byte;
          if (idx_q == '0) cin_d = in_cin;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = LOAD_B;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      LOAD_B: begin
        if (in_valid) begin
          b_d[int'(idx_q)*BYTE_W +: BYTE_W] = in_byte;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            cnt_d   = CNT_INIT;
            state_d = SETTLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          sum_d   = add_s;
          cout_d  = add_cout;
          of_d    = add_of;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      OUT: begin
        if (res_ready) begin
          idx_d   = '0;
          state_d = LOAD_A;
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      of_q    <= of_d;
    end
  end

  assign in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign res_valid = (state_q == OUT);
  assign busy      = (state_q != LOAD_A) || (idx_q != '0);
  assign add_a     = a_q;
  assign add_b     = b_q;
  assign add_cin   = cin_q;
  assign res_sum   = sum_q;
  assign res_cout  = cout_q;
  assign res_of    = of_q;

endmodule

// File: tb/tb_add_byte_loader.sv
// Randomised and directed bench for add_byte_loader with a behavioural adder
// standing in for the carry-bypass core.
module tb_add_byte_loader;
  import add_pkg::*;

  localparam int N             = N_DEFAULT;
  localparam int SETTLE_CYCLES = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_cin;
  logic [7:0]   in_byte;
  logic [N-1:0] add_a, add_b, add_s, res_sum;
  logic         add_cin, add_cout, add_of;
  logic         res_valid, res_ready, res_cout, res_of, busy;
  logic [N:0]   coreSum;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  // Adder core stand-in, purely combinational like the real one.
  assign coreSum  = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};
  assign add_s    = coreSum[N-1:0];
  assign add_cout = coreSum[N];
  assign add_of   = (add_a[N-1] == add_b[N-1]) && (add_s[N-1] != add_a[N-1]);

  add_byte_loader #(.N(N), .SETTLE_CYCLES(SETTLE_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout), .add_of(add_of),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .res_of(res_of),
    .busy(busy)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected {of, cout, sum} from integer arithmetic on the operand values.
  function automatic logic [N+1:0] modelAdd(input logic [N-1:0] a, b, input logic c);
    longint unsigned total;
    longint          ss;
    logic            ov;
    total = longint'(a) + longint'(b) + longint'(c);
    ss    = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    ov    = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    return {ov, total[N], total[N-1:0]};
  endfunction

  task automatic sendByte(input logic [7:0] b, input logic c, input int gap);
    int guard;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
      in_cin   = 1'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    in_cin   = c;
    guard    = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("acceptTimeout", 64'd0, 64'd1);
    @(posedge clk);
  endtask

  task automatic applyStimulus(input logic [N-1:0] a, b, input logic cin0, cinOther,
                               input int maxGap, input int readyDelay,
                               input bit holdAA, input bit keepReady);
    logic [N+1:0] exp;
    int           lat;
    exp = modelAdd(a, b, cin0);
    for (int k = 0; k < NBYTES; k++)
      sendByte(a[k*BYTE_W +: BYTE_W], (k == 0) ? cin0 : cinOther, $urandom_range(maxGap, 0));
    for (int k = 0; k < NBYTES; k++)
      sendByte(b[k*BYTE_W +: BYTE_W], 1'($urandom), $urandom_range(maxGap, 0));
    #1;
    in_valid = holdAA;
    in_byte  = 8'hAA;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (holdAA) checkOutput("inReadySettle", 64'(in_ready), 64'd0);
    end while (!res_valid && lat < 50);
    checkOutput("latency", 64'(lat), 64'(SETTLE_CYCLES + 1));
    checkOutput("sum", 64'(res_sum), 64'(exp[N-1:0]));
    checkOutput("cout", 64'(res_cout), 64'(exp[N]));
    checkOutput("of", 64'(res_of), 64'(exp[N+1]));
    checkOutput("busyOut", 64'(busy), 64'd1);
    if (!keepReady) begin
      for (int d = 0; d < readyDelay; d++) begin
        @(negedge clk);
        checkOutput("holdValid", 64'(res_valid), 64'd1);
        checkOutput("holdSum", 64'(res_sum), 64'(exp[N-1:0]));
        if (holdAA) checkOutput("inReadyOut", 64'(in_ready), 64'd0);
      end
      res_ready = 1'b1;
      in_valid  = 1'b0;
      @(negedge clk);
      res_ready = 1'b0;
    end else begin
      @(negedge clk);
    end
    checkOutput("validDrop", 64'(res_valid), 64'd0);
    checkOutput("inReadyAfter", 64'(in_ready), 64'd1);
    checkOutput("busyIdle", 64'(busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL globalTimeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    in_cin    = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstInReady", 64'(in_ready), 64'd1);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstValid", 64'(res_valid), 64'd0);
    checkOutput("rstA", 64'(add_a), 64'd0);
    checkOutput("rstSum", 64'(res_sum), 64'd0);
    rst = 1'b0;

    applyStimulus(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus(32'h0, 32'h0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    applyStimulus(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), 3, 5, 1'b1, 1'b0);

    // Reset in the middle of loading A discards the partial operand.
    sendByte(8'h12, 1'b1, 0);
    sendByte(8'h34, 1'b0, 0);
    sendByte(8'h56, 1'b1, 0);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("midLoadBusy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstA", 64'(add_a), 64'd0);
    checkOutput("midRstB", 64'(add_b), 64'd0);
    checkOutput("midRstCin", 64'(add_cin), 64'd0);
    checkOutput("midRstSum", 64'(res_sum), 64'd0);
    checkOutput("midRstCout", 64'(res_cout), 64'd0);
    checkOutput("midRstOf", 64'(res_of), 64'd0);
    checkOutput("midRstValid", 64'(res_valid), 64'd0);
    checkOutput("midRstInReady", 64'(in_ready), 64'd1);
    checkOutput("midRstBusy", 64'(busy), 64'd0);
    rst = 1'b0;
    applyStimulus(32'hA5A5_0F0F, 32'h1234_5678, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0);

    res_ready = 1'b1;
    applyStimulus(N'($urandom), N'($urandom), 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
    applyStimulus(N'($urandom), N'($urandom), 1'b0, 1'b1, 0, 0, 1'b0, 1'b1);
    res_ready = 1'b0;

    for (int t = 0; t < 8; t++)
      applyStimulus(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(3, 0), $urandom_range(4, 0), 1'($urandom), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
